or_stim_gen: RTL

- Stimulus side of the OR-gate self-test: drives every input vector into the DUT, then samples the checker's pass/fail line (`check`) for each one.
- Counts mismatches and latches the first failing vector.
- Sits between the test controller (`start`/`done`) and the DUT plus checker pair.
- Exhaustive sweep of 2^WIDTH vectors, one vector per SETTLE+1 clock cycles.

---
 rtl/or_stim_gen_if.sv | 25 ++
 rtl/or_stim_gen.sv | 92 +++++++++
 2 files changed

// File: rtl/or_stim_gen_if.sv
// Bus between the OR-gate stimulus generator, the DUT/checker pair and the test controller.
// Carries start, idata, check, busy, done and the error results (count, first failing vector).
interface or_stim_gen_if #(
    parameter int WIDTH = 10,
    parameter int ERR_W = 11
);
    logic               start;
    logic [0:WIDTH-1]   idata;
    logic               check;
    logic               busy;
    logic               done;
    logic [ERR_W-1:0]   err_count;
    logic               first_err_valid;
    logic [0:WIDTH-1]   first_err_vec;

    modport master (
        output start, check,
        input  idata, busy, done, err_count, first_err_valid, first_err_vec
    );

    modport slave (
        input  start, check,
        output idata, busy, done, err_count, first_err_valid, first_err_vec
    );
endinterface

// File: rtl/or_stim_gen.sv
// Exhaustive OR-gate stimulus generator: sweeps all 2^WIDTH vectors, samples check.
// Ports: clk, rst (sync, active-high), bus (slave: start/check in; idata/busy/done/results out).
module or_stim_gen #(
    parameter int WIDTH  = 10,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 11
) (
    input  logic clk,
    input  logic rst,
    or_stim_gen_if.slave bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t           state, state_nxt;
    logic [0:WIDTH-1] idata, idata_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [ERR_W-1:0] err, err_nxt;
    logic             fv, fv_nxt;
    logic [0:WIDTH-1] fvec, fvec_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idata <= '0;
            cnt   <= '0;
            err   <= '0;
            fv    <= 1'b0;
            fvec  <= '0;
        end else begin
            state <= state_nxt;
            idata <= idata_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
            fv    <= fv_nxt;
            fvec  <= fvec_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idata_nxt = idata;
        cnt_nxt   = cnt;
        err_nxt   = err;
        fv_nxt    = fv;
        fvec_nxt  = fvec;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = APPLY;
                    idata_nxt = '0;
                    cnt_nxt   = '0;
                    err_nxt   = '0;
                    fv_nxt    = 1'b0;
                    fvec_nxt  = '0;
                end
            end
            APPLY: begin
                if (cnt == LAST) state_nxt = SAMPLE;
                else cnt_nxt = cnt + 1'b1;
            end
            SAMPLE: begin
                if (!bus.check) begin
                    // Saturate rather than wrap.
                    if (err != '1) err_nxt = err + 1'b1;
                    if (!fv) begin
                        fv_nxt   = 1'b1;
                        fvec_nxt = idata;
                    end
                end
                // All-ones is the last vector; never wrap to 0 in a sweep.
                if (&idata) begin
                    state_nxt = DONE;
                end else begin
                    idata_nxt = idata + 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = APPLY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.idata           = idata;
    assign bus.busy            = (state == APPLY) || (state == SAMPLE);
    assign bus.done            = (state == DONE);
    assign bus.err_count       = err;
    assign bus.first_err_valid = fv;
    assign bus.first_err_vec   = fvec;
endmodule
